// File: rtl/mux4_rr_scheduler.sv
// Round-robin owner scheduler for a shared 4:1 data selector.
// Grants one requester at a time for a bounded burst, then blanks the
// selector strobe for a fixed number of dead cycles before the next owner,
// so the select lines only ever move while the selector is disabled.
module mux4_rr_scheduler #(
    parameter int unsigned HOLD_MAX   = 8,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel_a,
    output logic       sel_b,
    output logic       strobe_n,
    output logic       busy
);

    localparam int unsigned HW = $clog2(HOLD_MAX + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [1:0]    last_q, last_d;
    logic [3:0]    gnt_q, gnt_d;
    logic [1:0]    sel_q, sel_d;
    logic          strobe_n_q, strobe_n_d;
    logic          busy_q, busy_d;

    logic          win_vld;
    logic [1:0]    win_idx;

    // Circular priority search starting just after the last owner; the
    // last owner is checked last so it only wins when it is alone.
    always_comb begin
        logic [1:0] cand;
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Next-state and registered-output logic; the owner index lives in sel_q.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        gap_d      = gap_q;
        last_d     = last_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        strobe_n_d = strobe_n_q;

        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                    strobe_n_d = 1'b0;
                    hold_d     = HW'(1);
                end
            end
            ST_GRANT: begin
                if (!req[sel_q] || (hold_q == HW'(HOLD_MAX))) begin
                    state_d    = ST_GAP;
                    gnt_d      = 4'b0000;
                    strobe_n_d = 1'b1;
                    last_d     = sel_q;
                    gap_d      = GW'(1);
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_GAP: begin
                if (gap_q < GW'(GAP_CYCLES)) begin
                    gap_d = gap_q + GW'(1);
                end else if (win_vld) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 4'b0001 << win_idx;
                    sel_d      = win_idx;
                    strobe_n_d = 1'b0;
                    hold_d     = HW'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = 4'b0000;
                strobe_n_d = 1'b1;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            gap_q      <= '0;
            last_q     <= 2'd3;
            gnt_q      <= 4'b0000;
            sel_q      <= 2'd0;
            strobe_n_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            last_q     <= last_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            strobe_n_q <= strobe_n_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel_a    = sel_q[0];
    assign sel_b    = sel_q[1];
    assign strobe_n = strobe_n_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Directed bench for mux4_rr_scheduler with HOLD_MAX=4, GAP_CYCLES=1.
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, i.e. the values registered by that edge.
module tb_mux4_rr_scheduler;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       sel_a;
    logic       sel_b;
    logic       strobe_n;
    logic       busy;

    int n_tests;
    int n_fail;

    mux4_rr_scheduler #(
        .HOLD_MAX   (4),
        .GAP_CYCLES (1)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .sel_a    (sel_a),
        .sel_b    (sel_b),
        .strobe_n (strobe_n),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_gnt, input logic [1:0] e_sel,
                              input logic e_stb, input logic e_busy);
        chk({tag, ".gnt"},      32'(gnt),            32'(e_gnt));
        chk({tag, ".sel"},      32'({sel_b, sel_a}), 32'(e_sel));
        chk({tag, ".strobe_n"}, 32'(strobe_n),       32'(e_stb));
        chk({tag, ".busy"},     32'(busy),           32'(e_busy));
    endtask

    // n cycles of source src owning the selector
    task automatic grant_run(input string tag, input int src, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_out(tag, 4'b0001 << src, 2'(src), 1'b0, 1'b1);
        end
    endtask

    // n dead cycles with the select lines parked on the previous owner
    task automatic gap_run(input string tag, input int src, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            expect_out(tag, 4'b0000, 2'(src), 1'b1, 1'b1);
        end
    endtask

    task automatic idle_chk(input string tag, input int src);
        tick();
        expect_out(tag, 4'b0000, 2'(src), 1'b1, 1'b0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        req     = 4'b1111;
        #1;

        // reset held for 3 edges with every source requesting
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_out("reset", 4'b0000, 2'd0, 1'b1, 1'b0);
        end
        rst_n = 1'b1;

        // all requesting: order 0,1,2,3,0, 4-cycle grants, 1-cycle gaps
        grant_run("rr0", 0, 4);
        gap_run("rr0_gap", 0, 1);
        grant_run("rr1", 1, 4);
        gap_run("rr1_gap", 1, 1);
        grant_run("rr2", 2, 4);
        gap_run("rr2_gap", 2, 1);
        grant_run("rr3", 3, 4);
        gap_run("rr3_gap", 3, 1);
        grant_run("rr0_again", 0, 4);
        req = 4'b0000;
        gap_run("rr_end_gap", 0, 1);
        idle_chk("rr_idle", 0);

        // single held requester: source 2 regranted every 5 cycles
        req = 4'b0100;
        grant_run("single2_a", 2, 4);
        gap_run("single2_gap", 2, 1);
        grant_run("single2_b", 2, 2);

        // reset in the middle of the source 2 hold
        rst_n = 1'b0;
        req   = 4'b1111;
        tick();
        expect_out("midreset", 4'b0000, 2'd0, 1'b1, 1'b0);
        rst_n = 1'b1;
        grant_run("post_reset", 0, 1);

        // fairness: 0 and 3 alternate
        req = 4'b1001;
        grant_run("fair0_a", 0, 3);
        gap_run("fair0_gap", 0, 1);
        grant_run("fair3_a", 3, 4);
        gap_run("fair3_gap", 3, 1);
        grant_run("fair0_b", 0, 4);
        gap_run("fair0b_gap", 0, 1);
        grant_run("fair3_b", 3, 1);
        req = 4'b0000;
        gap_run("fair_end_gap", 3, 1);
        idle_chk("fair_idle", 3);

        // early release by source 1: grant cycles 1-3, gap cycle 4, idle cycle 5
        req = 4'b0010;
        grant_run("early1", 1, 3);
        req = 4'b0000;
        gap_run("early1_gap", 1, 1);
        idle_chk("early1_idle", 1);
        idle_chk("idle_stays", 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
